// File: rtl/siso.sv
// rtl/siso.sv - serial-in/serial-out shift register used as a fixed DEPTH-cycle delay line
module siso #(
    parameter int   DEPTH       = 4,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_input,
    output logic serial_output
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // sr_q[0] is the input stage; the loop is empty when DEPTH is 1, leaving a plain flop.
    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = serial_input;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= {DEPTH{RESET_VALUE}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign serial_output = sr_q[DEPTH-1];

endmodule

// File: tb/tb_siso.sv
// tb/tb_siso.sv - self-checking bench for siso (DEPTH=4/RV=0 and DEPTH=1/RV=1 instances)
module tb_siso;

    logic clk;
    logic rst;
    logic serial_input;
    logic out4;
    logic out1;

    int   pass_cnt;
    int   total_cnt;
    logic hist[$];

    siso #(.DEPTH(4), .RESET_VALUE(1'b0)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .serial_input (serial_input),
        .serial_output(out4)
    );

    siso #(.DEPTH(1), .RESET_VALUE(1'b1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .serial_input (serial_input),
        .serial_output(out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output of a delay line of the given depth: the bit sampled depth edges ago, else reset value.
    function automatic logic model_out(input int depth, input logic rv);
        int n;
        n = hist.size();
        if (n >= depth) return hist[n-depth];
        return rv;
    endfunction

    // Called at a falling edge; drives one bit, crosses one rising edge, returns at the next falling edge.
    task automatic drive(input logic b);
        serial_input = b;
        @(posedge clk);
        if (rst) hist.push_back(b);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        hist.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if (out4 !== 1'b0) $display("FAIL reset_out4: got %b want 0", out4);
        else pass_cnt++;
        total_cnt++;
        if (out1 !== 1'b1) $display("FAIL reset_out1: got %b want 1", out1);
        else pass_cnt++;
        serial_input = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (out4 !== 1'b0 || out1 !== 1'b1)
            $display("FAIL reset_hold: got %b/%b want 0/1", out4, out1);
        else pass_cnt++;
        rst = 1'b1;
        hist.delete();
    endtask

    task automatic test_latency();
        logic want[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(i == 0);
            total_cnt++;
            if (out4 !== want[i]) $display("FAIL latency_edge%0d: got %b want %b", i + 1, out4, want[i]);
            else pass_cnt++;
            total_cnt++;
            if (out1 !== model_out(1, 1'b1))
                $display("FAIL latency_d1_edge%0d: got %b want %b", i + 1, out1, model_out(1, 1'b1));
            else pass_cnt++;
        end
    endtask

    task automatic test_stream();
        logic seq[11] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            drive(seq[i]);
            total_cnt++;
            if (out4 !== model_out(4, 1'b0))
                $display("FAIL stream_%0d: got %b want %b", i, out4, model_out(4, 1'b0));
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (5) drive(1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        hist.delete();
        #1;
        total_cnt++;
        if (out4 !== 1'b0) $display("FAIL async_out4: got %b want 0", out4);
        else pass_cnt++;
        total_cnt++;
        if (out1 !== 1'b1) $display("FAIL async_out1: got %b want 1", out1);
        else pass_cnt++;
        total_cnt++;
        if (u_dut4.sr_q !== 4'b0000) $display("FAIL async_sr: got %b want 0000", u_dut4.sr_q);
        else pass_cnt++;
        serial_input = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1);
            total_cnt++;
            if (out4 !== (i >= 3)) $display("FAIL midreset_edge%0d: got %b want %b", i + 1, out4, (i >= 3));
            else pass_cnt++;
        end
    endtask

    task automatic test_constant();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1);
            total_cnt++;
            if (out4 !== (i >= 3)) $display("FAIL const_edge%0d: got %b want %b", i + 1, out4, (i >= 3));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) apply_reset();
            drive(1'($urandom_range(0, 1)));
            total_cnt++;
            if (out4 !== model_out(4, 1'b0))
                $display("FAIL rand4_%0d: got %b want %b", i, out4, model_out(4, 1'b0));
            else pass_cnt++;
            total_cnt++;
            if (out1 !== model_out(1, 1'b1))
                $display("FAIL rand1_%0d: got %b want %b", i, out1, model_out(1, 1'b1));
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        serial_input = 1'b0;
        #1 rst = 1'b0;
        test_reset();
        test_latency();
        test_stream();
        test_async_reset();
        test_constant();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
